uart_bus_port: RTL and testbench

// - Byte-wide 8N1 UART peripheral on the odd (LDS) lane of the 68000 bus, the stage directly downstream of bus control.
// - Bus control decodes the peripheral window into CS_IN. This block returns ACK, which bus control folds into DTACK.
// - 16-deep TX and RX FIFOs. IRQ is asserted while RX data is pending.

---
 rtl/uart_bus_port.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_bus_port.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_port.sv
// Byte-wide 8N1 UART on the 68000 odd byte lane with TX/RX FIFOs.
// Each bus access has exactly one side effect. Bus control folds ACK into DTACK.

module uart_bus_port #(
  parameter int CLKDIV  = 87,
  parameter int FIFO_AW = 4
) (
  input  logic       CPUCLK_IN,
  input  logic       RESET_IN,
  input  logic       CS_IN,
  input  logic       AS_IN,
  input  logic       WR_IN,
  input  logic       LDS_IN,
  input  logic       REG_IN,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       ACK,
  output logic       IRQ,
  input  logic       RXD_IN,
  output logic       TXD
);

  localparam logic [15:0]      C_FULL  = 16'(CLKDIV - 1);
  localparam logic [15:0]      C_HALF  = 16'(CLKDIV / 2 - 1);
  localparam int               DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] C_DEPTH = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus access decode
  logic w_acc, w_start, r_acc_d;
  logic w_rd, w_rd_data, w_wr_data, w_wr_stat;
  logic [7:0] r_data_out, w_status, w_rd_value;
  logic r_irq, r_ferr, r_rovr;

  // FIFO index 0 = TX, 1 = RX
  logic [1:0]      w_push, w_pop, w_empty, w_full;
  logic [1:0][7:0] w_wdata, w_head;

  logic        w_tx_pop, w_tx_tick, w_tx_idle, w_txd;
  state_t      r_tx_state, w_tx_state_next;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;

  logic        r_rxd_meta, r_rxd_sync, r_rxd_prev, w_rx_fall;
  logic        w_rx_tick, w_rx_push, w_ferr_set, w_rovr_set;
  state_t      r_rx_state, w_rx_state_next;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;

  assign w_acc     = CS_IN & AS_IN & LDS_IN;
  assign w_start   = w_acc & ~r_acc_d;
  assign w_rd      = w_start & ~WR_IN;
  assign w_rd_data = w_start & ~WR_IN & ~REG_IN;
  assign w_wr_data = w_start & WR_IN & ~REG_IN;
  assign w_wr_stat = w_start & WR_IN & REG_IN;

  assign ACK      = w_acc & r_acc_d;
  assign DATA_OE  = w_acc & ~WR_IN;
  assign DATA_OUT = r_data_out;
  assign IRQ      = r_irq;
  assign TXD      = w_txd;

  assign w_tx_idle  = (r_tx_state == S_IDLE) & w_empty[0];
  assign w_status   = {3'b000, r_ferr, r_rovr, w_tx_idle, ~w_full[0], ~w_empty[1]};
  assign w_rd_value = REG_IN ? w_status : (w_empty[1] ? 8'h00 : w_head[1]);

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      r_acc_d    <= 1'b0;
      r_data_out <= 8'h00;
      r_irq      <= 1'b0;
      r_ferr     <= 1'b0;
      r_rovr     <= 1'b0;
    end else begin
      r_acc_d <= w_acc;
      if (w_rd) r_data_out <= w_rd_value;
      r_irq  <= ~w_empty[1];
      // A set in the same cycle as a W1C clear wins
      r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_stat & DATA_IN[4]));
      r_rovr <= w_rovr_set | (r_rovr & ~(w_wr_stat & DATA_IN[3]));
    end
  end

  assign w_push  = {w_rx_push, w_wr_data};
  assign w_pop   = {w_rd_data, w_tx_pop};
  assign w_wdata = {r_rx_shift, DATA_IN};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push, w_do_pop;

    assign w_empty[gi] = (r_count == '0);
    assign w_full[gi]  = (r_count == C_DEPTH);
    assign w_do_push   = w_push[gi] & ~w_full[gi];
    assign w_do_pop    = w_pop[gi] & ~w_empty[gi];
    assign w_head[gi]  = r_mem[r_rd_ptr];

    always_ff @(posedge CPUCLK_IN) begin
      if (w_do_push) r_mem[r_wr_ptr] <= w_wdata[gi];
    end

    always_ff @(posedge CPUCLK_IN) begin
      if (RESET_IN) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_do_push & ~w_do_pop)      r_count <= r_count + 1'b1;
        else if (~w_do_push & w_do_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  // Transmitter
  assign w_tx_tick = (r_tx_cnt == C_FULL);

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) r_tx_state <= S_IDLE;
    else          r_tx_state <= w_tx_state_next;
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    case (r_tx_state)
      S_IDLE:  if (~w_empty[0]) w_tx_state_next = S_START;
      S_START: if (w_tx_tick) w_tx_state_next = S_DATA;
      S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_state_next = S_STOP;
      S_STOP:  if (w_tx_tick) w_tx_state_next = w_empty[0] ? S_IDLE : S_START;
      default: w_tx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_pop = 1'b0;
    w_txd    = 1'b1;
    case (r_tx_state)
      S_IDLE:  w_tx_pop = ~w_empty[0];
      S_START: w_txd = 1'b0;
      S_DATA:  w_txd = r_tx_shift[0];
      S_STOP:  w_tx_pop = w_tx_tick & ~w_empty[0];
      default: w_txd = 1'b1;
    endcase
  end

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      if (r_tx_state == S_IDLE || w_tx_tick) r_tx_cnt <= '0;
      else                                   r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_tx_pop) begin
        r_tx_shift <= w_head[0];
        r_tx_bit   <= '0;
      end else if (r_tx_state == S_DATA && w_tx_tick) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        r_tx_bit   <= r_tx_bit + 1'b1;
      end
    end
  end

  // Receiver; the line is asynchronous so it is synchronized before use
  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= RXD_IN;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  assign w_rx_fall = r_rxd_prev & ~r_rxd_sync;
  assign w_rx_tick = (r_rx_state == S_START) ? (r_rx_cnt == C_HALF) : (r_rx_cnt == C_FULL);

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) r_rx_state <= S_IDLE;
    else          r_rx_state <= w_rx_state_next;
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:  if (w_rx_fall) w_rx_state_next = S_START;
      S_START: if (w_rx_tick) w_rx_state_next = r_rxd_sync ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_state_next = S_STOP;
      S_STOP:  if (w_rx_tick) w_rx_state_next = S_IDLE;
      default: w_rx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_push  = 1'b0;
    w_ferr_set = 1'b0;
    if (r_rx_state == S_STOP && w_rx_tick) begin
      w_rx_push  = r_rxd_sync;
      w_ferr_set = ~r_rxd_sync;
    end
    w_rovr_set = w_rx_push & w_full[1];
  end

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      if (r_rx_state == S_IDLE || w_rx_tick) r_rx_cnt <= '0;
      else                                   r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_state == S_IDLE) begin
        r_rx_bit <= '0;
      end else if (r_rx_state == S_DATA && w_rx_tick) begin
        r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_port.sv
// Directed bench for uart_bus_port with an 8-cycle bit period.

module tb_uart_bus_port;

  logic       clk = 1'b0;
  logic       rst, cs, as_s, wr, lds, rsel, rxd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe, ack, irq, txd;
  int         tests = 0;
  int         failed = 0;
  logic [7:0] q;
  logic [9:0] fr;

  always #5 clk = ~clk;

  uart_bus_port #(.CLKDIV(8), .FIFO_AW(4)) dut (
    .CPUCLK_IN(clk), .RESET_IN(rst), .CS_IN(cs), .AS_IN(as_s), .WR_IN(wr),
    .LDS_IN(lds), .REG_IN(rsel), .DATA_IN(din), .DATA_OUT(dout),
    .DATA_OE(oe), .ACK(ack), .IRQ(irq), .RXD_IN(rxd), .TXD(txd)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One bus access; ACK must be low in the start cycle, high after it, low once released
  task automatic bus(input logic w, input logic r, input logic [7:0] d, input int hold,
                     output logic [7:0] rd);
    @(negedge clk);
    cs = 1'b1; as_s = 1'b1; lds = 1'b1; wr = w; rsel = r; din = d;
    #1;
    check("ack_at_start", {7'b0, ack}, 8'h00);
    check("data_oe", {7'b0, oe}, {7'b0, ~w});
    repeat (hold) @(negedge clk);
    check("ack_held", {7'b0, ack}, 8'h01);
    rd = dout;
    cs = 1'b0; as_s = 1'b0; lds = 1'b0;
    #1 check("ack_release", {7'b0, ack}, 8'h00);
    $display("[TB] bus %s %s din=%02h dout=%02h", w ? "WR" : "RD", r ? "STATUS" : "DATA", d, rd);
  endtask

  task automatic rd_chk(input logic r, input logic [7:0] exp, input string tag);
    logic [7:0] v;
    bus(1'b0, r, 8'h00, 1, v);
    check(tag, v, exp);
  endtask

  task automatic wr_reg(input logic r, input logic [7:0] d);
    logic [7:0] v;
    bus(1'b1, r, d, 1, v);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = f[i];
      repeat (7) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
    $display("[TB] rx frame %02h stop=%0d", b, stop);
  endtask

  // Decodes one frame from TXD, sampling each bit mid-period
  task automatic tx_capture(input logic [7:0] exp, input string tag);
    int n;
    logic [7:0] b;
    n = 0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_timeout", {7'b0, (n < 200)}, 8'h01);
    repeat (4) @(negedge clk);
    check("tx_start_bit", {7'b0, txd}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk);
      b[i] = txd;
    end
    repeat (8) @(negedge clk);
    check("tx_stop_bit", {7'b0, txd}, 8'h01);
    check(tag, b, exp);
    $display("[TB] tx frame %02h", b);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; as_s = 1'b0; wr = 1'b0; lds = 1'b0; rsel = 1'b0;
    din = 8'h00; rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", dout, 8'h00);
    check("rst_ack", {7'b0, ack}, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_txd", {7'b0, txd}, 8'h01);
    check("rst_oe", {7'b0, oe}, 8'h00);
    rst = 1'b0;
    rd_chk(1'b1, 8'h06, "status_after_reset");

    // Single byte: exact frame timing
    wr_reg(1'b0, 8'h55);
    fr = {1'b1, 8'h55, 1'b0};
    repeat (5) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("tx55_bit", {7'b0, txd}, {7'b0, fr[k]});
      if (k < 9) repeat (8) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    rd_chk(1'b1, 8'h06, "tx_idle_after_frame");

    // TX FIFO overflow: 0xFF occupies the shifter, then 17 writes
    wr_reg(1'b0, 8'hFF);
    for (int i = 1; i <= 17; i++) wr_reg(1'b0, 8'(i));
    rd_chk(1'b1, 8'h00, "tx_full_status");
    for (int i = 1; i <= 16; i++) tx_capture(8'(i), "tx_fifo_byte");
    repeat (6) @(negedge clk);
    rd_chk(1'b1, 8'h06, "tx_17th_dropped");

    // RX single frame, then empty read
    rx_send(8'hA3, 1'b1);
    repeat (2) @(negedge clk);
    check("irq_set", {7'b0, irq}, 8'h01);
    rd_chk(1'b0, 8'hA3, "rx_a3");
    @(negedge clk);
    check("irq_clear", {7'b0, irq}, 8'h00);
    rd_chk(1'b0, 8'h00, "rx_empty_read");

    // RX overrun
    for (int i = 0; i < 17; i++) rx_send(8'(8'h30 + i), 1'b1);
    repeat (2) @(negedge clk);
    rd_chk(1'b1, 8'h0F, "rovr_status");
    wr_reg(1'b1, 8'h08);
    rd_chk(1'b1, 8'h07, "rovr_cleared");
    for (int i = 0; i < 16; i++) rd_chk(1'b0, 8'(8'h30 + i), "rx_fifo_byte");
    rd_chk(1'b1, 8'h06, "rx_drained");

    // Framing error and start glitch
    rx_send(8'h5A, 1'b0);
    repeat (2) @(negedge clk);
    rd_chk(1'b1, 8'h16, "ferr_status");
    check("ferr_no_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    rd_chk(1'b1, 8'h16, "glitch_ignored");
    wr_reg(1'b1, 8'h10);
    rd_chk(1'b1, 8'h06, "ferr_cleared");

    // Long access pops once
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    repeat (2) @(negedge clk);
    bus(1'b0, 1'b0, 8'h00, 20, q);
    check("long_read", q, 8'h11);
    rd_chk(1'b0, 8'h22, "after_long_read");
    rd_chk(1'b0, 8'h00, "after_long_empty");

    // Reset in the middle of a TX frame
    rx_send(8'h77, 1'b1);
    repeat (2) @(negedge clk);
    wr_reg(1'b0, 8'h00);
    wr_reg(1'b0, 8'hC3);
    rd_chk(1'b1, 8'h03, "status_mid_tx");
    repeat (13) @(negedge clk);
    check("txd_low_before_rst", {7'b0, txd}, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_txd", {7'b0, txd}, 8'h01);
    check("rst_mid_dout", dout, 8'h00);
    check("rst_mid_irq", {7'b0, irq}, 8'h00);
    rst = 1'b0;
    rd_chk(1'b1, 8'h06, "status_after_mid_rst");
    repeat (30) @(negedge clk);
    check("txd_idle_after_rst", {7'b0, txd}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
